// File: rtl/dual_helix_pkg.sv
// -----------------------------------------------------------------------------
// dual_helix_pkg
// Shared types for the dual-helix SoC slice:
//   - dhs_apb_req_t / dhs_apb_resp_t : APB master request / slave response
//   - LDR_CMD_WRITE / LDR_CMD_READ   : command bytes of the UART loader frames
//   - ldr_state_e                    : UART loader FSM states
//   - ldr_le_byte()                  : little-endian byte select from a word
// -----------------------------------------------------------------------------
package dual_helix_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } dhs_apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } dhs_apb_resp_t;

  localparam logic [7:0] LDR_CMD_WRITE = 8'hA5;
  localparam logic [7:0] LDR_CMD_READ  = 8'h5A;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_ADDR,
    LDR_DATA,
    LDR_SETUP,
    LDR_ACCESS,
    LDR_RESP
  } ldr_state_e;

  // Byte idx (0 = least significant) of a 32-bit word.
  function automatic logic [7:0] ldr_le_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_apb_loader.sv
// -----------------------------------------------------------------------------
// uart_apb_loader
// Turns a byte stream from a UART receiver into single APB transfers and
// answers each transfer with response bytes to the UART transmitter.
//   write frame : A5, addr[0..3], data[0..3]  -> response: status
//   read  frame : 5A, addr[0..3]              -> response: rdata[0..3], status
//   status      : NAK_BYTE when pslverr=1, otherwise ACK_BYTE
// A partial frame is abandoned when BYTE_TIMEOUT cycles pass without a byte;
// an unknown command byte is dropped. Both raise a one-cycle frame_err_o.
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   rst_i        : synchronous active-high reset
//   rx_data_i    : received byte          rx_valid_i : rx_data_i valid
//   rx_ready_o   : loader accepts a byte this cycle
//   tx_data_o    : response byte          tx_valid_o : tx_data_o valid
//   tx_ready_i   : transmitter accepts tx_data_o
//   apb_req_o    : APB master request (all-zero outside a transfer)
//   apb_resp_i   : APB response (pready, prdata, pslverr)
//   busy_o       : high whenever the loader is not idle
//   frame_err_o  : one-cycle pulse on unknown command or byte timeout
// -----------------------------------------------------------------------------
module uart_apb_loader
  import dual_helix_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 1024,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output dhs_apb_req_t  apb_req_o,
  input  dhs_apb_resp_t apb_resp_i,
  output logic          busy_o,
  output logic          frame_err_o
);

  localparam int unsigned       CNT_W     = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(BYTE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  IDLE_ONE  = CNT_W'(1);

  ldr_state_e       r_state;
  ldr_state_e       w_next_state;

  logic             r_is_write;
  logic [1:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_slverr;
  logic [2:0]       r_tx_idx;
  logic             r_frame_err;

  logic             w_cmd_ok;
  logic             w_rx_fire;
  logic             w_tx_fire;
  logic             w_tx_last;
  logic [7:0]       w_status;
  logic [7:0]       w_tx_byte;

  assign w_cmd_ok  = (rx_data_i == LDR_CMD_WRITE) || (rx_data_i == LDR_CMD_READ);
  assign w_rx_fire = rx_valid_i && rx_ready_o;
  assign w_tx_fire = tx_valid_o && tx_ready_i;
  assign w_status  = r_slverr ? NAK_BYTE : ACK_BYTE;

  // A write answers with the status byte only; a read sends rdata bytes 0..3
  // first, so index 4 is the status slot.
  assign w_tx_last = r_is_write || (r_tx_idx == 3'd4);
  assign w_tx_byte = w_tx_last ? w_status : ldr_le_byte(r_rdata, r_tx_idx[1:0]);

  assign frame_err_o = r_frame_err;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= LDR_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    rx_ready_o   = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    apb_req_o    = '0;
    busy_o       = 1'b1;

    unique case (r_state)
      LDR_IDLE: begin
        busy_o     = 1'b0;
        rx_ready_o = 1'b1;
        if (rx_valid_i && w_cmd_ok) begin
          w_next_state = LDR_ADDR;
        end
      end

      LDR_ADDR: begin
        rx_ready_o = 1'b1;
        // An arriving byte always beats the timeout in the same cycle.
        if (rx_valid_i) begin
          if (r_byte_cnt == 2'd3) begin
            w_next_state = r_is_write ? LDR_DATA : LDR_SETUP;
          end
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_next_state = LDR_IDLE;
        end
      end

      LDR_DATA: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          if (r_byte_cnt == 2'd3) begin
            w_next_state = LDR_SETUP;
          end
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_next_state = LDR_IDLE;
        end
      end

      LDR_SETUP: begin
        apb_req_o.psel   = 1'b1;
        apb_req_o.paddr  = r_addr;
        apb_req_o.pwrite = r_is_write;
        apb_req_o.pwdata = r_wdata;
        apb_req_o.pstrb  = r_is_write ? 4'hF : 4'h0;
        w_next_state     = LDR_ACCESS;
      end

      LDR_ACCESS: begin
        // No timeout here: a slave that never answers holds the loader until
        // reset, which is the only way psel may drop mid-transfer.
        apb_req_o.psel    = 1'b1;
        apb_req_o.penable = 1'b1;
        apb_req_o.paddr   = r_addr;
        apb_req_o.pwrite  = r_is_write;
        apb_req_o.pwdata  = r_wdata;
        apb_req_o.pstrb   = r_is_write ? 4'hF : 4'h0;
        if (apb_resp_i.pready) begin
          w_next_state = LDR_RESP;
        end
      end

      LDR_RESP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = w_tx_byte;
        if (tx_ready_i && w_tx_last) begin
          w_next_state = LDR_IDLE;
        end
      end

      default: begin
        w_next_state = LDR_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame assembly, idle timer, APB capture and response sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_is_write  <= 1'b0;
      r_byte_cnt  <= 2'd0;
      r_idle_cnt  <= '0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_slverr    <= 1'b0;
      r_tx_idx    <= 3'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      unique case (r_state)
        LDR_IDLE: begin
          r_byte_cnt <= 2'd0;
          r_idle_cnt <= '0;
          r_tx_idx   <= 3'd0;
          if (rx_valid_i) begin
            if (w_cmd_ok) begin
              r_is_write <= (rx_data_i == LDR_CMD_WRITE);
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end

        LDR_ADDR, LDR_DATA: begin
          if (w_rx_fire) begin
            // The 2-bit counter wraps to 0 after the 4th byte, ready for DATA.
            if (r_state == LDR_ADDR) begin
              r_addr[8*r_byte_cnt +: 8] <= rx_data_i;
            end else begin
              r_wdata[8*r_byte_cnt +: 8] <= rx_data_i;
            end
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_frame_err <= 1'b1;
            r_idle_cnt  <= '0;
            r_byte_cnt  <= 2'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_ONE;
          end
        end

        LDR_ACCESS: begin
          if (apb_resp_i.pready) begin
            r_rdata  <= apb_resp_i.prdata;
            r_slverr <= apb_resp_i.pslverr;
          end
        end

        LDR_RESP: begin
          if (w_tx_fire && !w_tx_last) begin
            r_tx_idx <= r_tx_idx + 3'd1;
          end
        end

        default: begin
          r_byte_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_loader
// Directed scenarios for uart_apb_loader (BYTE_TIMEOUT=16). A frame-level
// model tracks accepted bytes, the APB transfer they imply and the response
// bytes owed, and is compared to the DUT on every falling edge. Scenario code
// adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_apb_loader;
  import dual_helix_pkg::*;

  localparam int TO = 16;

  // model activity phases
  localparam int P_RX     = 0;  // collecting frame bytes
  localparam int P_SETUP  = 1;  // first APB cycle
  localparam int P_ACCESS = 2;  // waiting for pready
  localparam int P_TX     = 3;  // response bytes owed

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  dhs_apb_req_t  apb_req;
  dhs_apb_resp_t apb_resp;
  logic          busy;
  logic          frame_err;

  int            pready_delay;
  logic [31:0]   prdata_cfg;
  logic          slverr_cfg;
  int            acc_cnt = 0;
  logic          w_pready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_apb_loader #(.BYTE_TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .apb_req_o   (apb_req),
    .apb_resp_i  (apb_resp),
    .busy_o      (busy),
    .frame_err_o (frame_err)
  );

  // APB slave: answers after pready_delay wait cycles in ACCESS
  assign w_pready = apb_req.psel && apb_req.penable && (acc_cnt >= pready_delay);
  assign apb_resp = {w_pready, prdata_cfg, slverr_cfg};

  always @(posedge clk) begin
    if (apb_req.psel && apb_req.penable && !w_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Model state and observations
  // ---------------------------------------------------------------------------
  bit          model_ok = 0;
  int          phase = P_RX;
  logic [7:0]  fq[$];
  logic [7:0]  resp_q[$];
  int          idle_edges = 0;
  bit          err_now = 0;
  bit          err_next;
  bit          exp_write;
  logic [31:0] exp_addr, exp_wdata;

  logic [7:0]  tx_log[$];
  int          ncyc = 0;
  int          setup_count = 0;
  int          err_cycles = 0;
  int          acc_run = 0;
  int          last_access_cycles = 0;
  int          last_acc_ncyc = 0;
  int          first_tx_ncyc = 0;
  bit          prev_txv = 0;
  logic [31:0] cap_paddr, cap_pwdata;
  logic [3:0]  cap_pstrb;
  logic        cap_pwrite;

  always @(negedge clk) begin
    ncyc++;
    if (model_ok) begin
      chk(frame_err == err_now, "frame_err", frame_err, err_now);
      chk(rx_ready == (phase == P_RX), "rx_ready", rx_ready, phase == P_RX);
      chk(busy == (phase != P_RX || fq.size() != 0), "busy", busy,
          phase != P_RX || fq.size() != 0);
      chk(tx_valid == (phase == P_TX), "tx_valid", tx_valid, phase == P_TX);
      if (phase == P_SETUP || phase == P_ACCESS) begin
        chk(apb_req.psel == 1'b1, "psel", apb_req.psel, 1);
        chk(apb_req.penable == (phase == P_ACCESS), "penable", apb_req.penable,
            phase == P_ACCESS);
        chk(apb_req.paddr == exp_addr, "paddr", apb_req.paddr, exp_addr);
        chk(apb_req.pwrite == exp_write, "pwrite", apb_req.pwrite, exp_write);
        chk(apb_req.pstrb == (exp_write ? 4'hF : 4'h0), "pstrb", apb_req.pstrb,
            exp_write ? 4'hF : 4'h0);
        if (exp_write) chk(apb_req.pwdata == exp_wdata, "pwdata", apb_req.pwdata, exp_wdata);
      end else begin
        chk(apb_req == '0, "apb_idle", {63'd0, |apb_req}, 0);
      end
      if (phase == P_TX && resp_q.size() != 0)
        chk(tx_data == resp_q[0], "tx_data", tx_data, resp_q[0]);
    end

    // observations used by scenario-level literal checks
    if (apb_req.psel && !apb_req.penable) begin
      setup_count++;
      cap_paddr = apb_req.paddr; cap_pwdata = apb_req.pwdata;
      cap_pstrb = apb_req.pstrb; cap_pwrite = apb_req.pwrite;
      acc_run = 0;
    end
    if (apb_req.psel && apb_req.penable) begin
      acc_run++;
      last_access_cycles = acc_run;
    end
    if (tx_valid && !prev_txv) first_tx_ncyc = ncyc;
    prev_txv = tx_valid;
    if (frame_err) err_cycles++;
    if (rx_valid && rx_ready && !rst) last_acc_ncyc = ncyc;
    if (tx_valid && tx_ready && !rst) tx_log.push_back(tx_data);

    // advance the model across the coming rising edge
    err_next = 0;
    if (rst) begin
      fq.delete(); resp_q.delete();
      phase = P_RX; idle_edges = 0; model_ok = 1;
    end else if (model_ok) begin
      case (phase)
        P_RX: begin
          if (rx_valid) begin
            idle_edges = 0;
            if (fq.size() == 0 && rx_data != 8'hA5 && rx_data != 8'h5A) begin
              err_next = 1;
            end else begin
              fq.push_back(rx_data);
              if ((fq[0] == 8'hA5 && fq.size() == 9) || (fq[0] == 8'h5A && fq.size() == 5)) begin
                exp_write = (fq[0] == 8'hA5);
                exp_addr  = {fq[4], fq[3], fq[2], fq[1]};
                if (exp_write) exp_wdata = {fq[8], fq[7], fq[6], fq[5]};
                fq.delete();
                phase = P_SETUP;
              end
            end
          end else if (fq.size() != 0) begin
            idle_edges++;
            if (idle_edges == TO) begin
              err_next = 1; fq.delete(); idle_edges = 0;
            end
          end
        end
        P_SETUP: phase = P_ACCESS;
        P_ACCESS: begin
          if (apb_resp.pready) begin
            if (!exp_write)
              for (int i = 0; i < 4; i++) resp_q.push_back(apb_resp.prdata[8*i +: 8]);
            resp_q.push_back(apb_resp.pslverr ? 8'h15 : 8'h06);
            phase = P_TX;
          end
        end
        P_TX: begin
          if (tx_ready) begin
            void'(resp_q.pop_front());
            if (resp_q.size() == 0) phase = P_RX;
          end
        end
        default: phase = P_RX;
      endcase
    end
    err_now = err_next;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk); ok = rx_ready;
      @(posedge clk); n++;
    end
    #1 rx_valid = 1'b0;
    if (!ok) chk(0, "rx_accept_timeout", 0, 1);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_tx(input int target);
    int k = 0;
    while (tx_log.size() < target && k < 500) begin
      @(posedge clk); k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(tx_log.size() >= target, "tx_count", tx_log.size(), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int base, errs, setups, k;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    pready_delay = 0; prdata_cfg = 32'h0; slverr_cfg = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk(apb_req == '0, "rst_apb", {63'd0, |apb_req}, 0);
    chk(tx_valid == 1'b0, "rst_tx_valid", tx_valid, 0);
    chk(rx_ready == 1'b1, "rst_rx_ready", rx_ready, 1);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(frame_err == 1'b0, "rst_frame_err", frame_err, 0);
    @(posedge clk); #1;

    // write, immediate pready
    base = tx_log.size();
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    wait_tx(base + 1);
    chk(cap_paddr == 32'h1000_0000, "wr_paddr", cap_paddr, 32'h1000_0000);
    chk(cap_pwdata == 32'hDEAD_BEEF, "wr_pwdata", cap_pwdata, 32'hDEAD_BEEF);
    chk(cap_pstrb == 4'hF, "wr_pstrb", cap_pstrb, 4'hF);
    chk(cap_pwrite == 1'b1, "wr_pwrite", cap_pwrite, 1);
    chk(tx_log[base] == 8'h06, "wr_ack", tx_log[base], 8'h06);
    // last byte seen one cycle before its edge, so tx appears 3 samples later
    chk(first_tx_ncyc - last_acc_ncyc == 3, "wr_latency", first_tx_ncyc - last_acc_ncyc, 3);
    chk(last_access_cycles == 1, "wr_access_cycles", last_access_cycles, 1);

    // read
    prdata_cfg = 32'h1234_5678;
    base = tx_log.size();
    send_bytes('{8'h5A, 8'h04, 8'h00, 8'h00, 8'h10});
    wait_tx(base + 5);
    chk(cap_paddr == 32'h1000_0004, "rd_paddr", cap_paddr, 32'h1000_0004);
    chk(cap_pwrite == 1'b0, "rd_pwrite", cap_pwrite, 0);
    chk(cap_pstrb == 4'h0, "rd_pstrb", cap_pstrb, 4'h0);
    chk({tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3], tx_log[base+4]}
        == 40'h78_56_34_12_06, "rd_bytes",
        {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3], tx_log[base+4]},
        40'h78_56_34_12_06);

    // write with pready after 5 wait cycles and pslverr
    pready_delay = 5; slverr_cfg = 1'b1;
    base = tx_log.size();
    send_bytes('{8'hA5, 8'h20, 8'h00, 8'h00, 8'h10, 8'h44, 8'h33, 8'h22, 8'h11});
    wait_tx(base + 1);
    chk(last_access_cycles == 6, "slow_access_cycles", last_access_cycles, 6);
    chk(cap_paddr == 32'h1000_0020, "slow_paddr", cap_paddr, 32'h1000_0020);
    chk(tx_log[base] == 8'h15, "slow_nak", tx_log[base], 8'h15);
    pready_delay = 0; slverr_cfg = 1'b0;

    // unknown command byte, then a good read frame
    errs = err_cycles; setups = setup_count;
    send_byte(8'h3C);
    repeat (3) @(posedge clk); #1;
    chk(err_cycles == errs + 1, "badcmd_err_pulse", err_cycles - errs, 1);
    chk(setup_count == setups, "badcmd_no_apb", setup_count - setups, 0);
    prdata_cfg = 32'hAABB_CCDD;
    base = tx_log.size();
    send_bytes('{8'h5A, 8'h08, 8'h00, 8'h00, 8'h10});
    wait_tx(base + 5);
    chk(cap_paddr == 32'h1000_0008, "after_err_paddr", cap_paddr, 32'h1000_0008);
    chk(tx_log[base] == 8'hDD, "after_err_b0", tx_log[base], 8'hDD);
    chk(tx_log[base+4] == 8'h06, "after_err_ack", tx_log[base+4], 8'h06);

    // byte timeout: 16 idle edges after a partial frame
    errs = err_cycles;
    send_bytes('{8'hA5, 8'h00});
    repeat (TO) @(posedge clk);
    @(negedge clk);
    chk(frame_err == 1'b1, "timeout_err", frame_err, 1);
    chk(busy == 1'b0, "timeout_idle", busy, 0);
    @(posedge clk); #1;

    // byte arriving on the timeout edge wins
    errs = err_cycles;
    send_bytes('{8'hA5, 8'h00});
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h00);
    @(negedge clk);
    chk(frame_err == 1'b0, "late_byte_no_err", frame_err, 0);
    chk(busy == 1'b1, "late_byte_busy", busy, 1);
    @(posedge clk); #1;
    base = tx_log.size();
    send_bytes('{8'h00, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04});
    wait_tx(base + 1);
    chk(cap_pwdata == 32'h0403_0201, "late_pwdata", cap_pwdata, 32'h0403_0201);
    chk(tx_log[base] == 8'h06, "late_ack", tx_log[base], 8'h06);
    chk(err_cycles == errs, "late_no_err", err_cycles - errs, 0);

    // transmitter stalled for 10 cycles during a read response
    prdata_cfg = 32'hCAFE_F00D;
    tx_ready = 1'b0;
    base = tx_log.size();
    send_bytes('{8'h5A, 8'h0C, 8'h00, 8'h00, 8'h10});
    k = 0;
    while (!tx_valid && k < 50) begin @(posedge clk); k++; end
    chk(tx_valid == 1'b1, "stall_tx_valid", tx_valid, 1);
    repeat (10) begin
      @(negedge clk);
      chk(tx_data == 8'h0D && tx_valid, "stall_hold", tx_data, 8'h0D);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_tx(base + 5);
    chk({tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3], tx_log[base+4]}
        == 40'h0D_F0_FE_CA_06, "stall_bytes",
        {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3], tx_log[base+4]},
        40'h0D_F0_FE_CA_06);

    // reset while the APB transfer is waiting in ACCESS
    pready_delay = 1000;
    base = tx_log.size();
    send_bytes('{8'hA5, 8'h30, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00});
    k = 0;
    while (!(apb_req.psel && apb_req.penable) && k < 50) begin @(posedge clk); k++; end
    chk(apb_req.psel && apb_req.penable, "mid_access_reached", apb_req.penable, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(apb_req.psel == 1'b0, "rst_mid_psel", apb_req.psel, 0);
    chk(apb_req == '0, "rst_mid_apb", {63'd0, |apb_req}, 0);
    chk(tx_valid == 1'b0, "rst_mid_tx_valid", tx_valid, 0);
    chk(rx_ready == 1'b1, "rst_mid_rx_ready", rx_ready, 1);
    chk(busy == 1'b0, "rst_mid_busy", busy, 0);
    chk(frame_err == 1'b0, "rst_mid_frame_err", frame_err, 0);
    repeat (10) @(posedge clk); #1;
    chk(tx_log.size() == base, "rst_mid_no_tx", tx_log.size(), base);
    pready_delay = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_apb_loader.md
UART_APB_LOADER -- requirements
Module: uart_apb_loader

Interface
REQ-001 Parameter BYTE_TIMEOUT, default 1024, is the number of idle clk_i cycles allowed between bytes of one frame.
REQ-002 Parameter ACK_BYTE, default 8'h06, is the status byte returned for an OKAY APB transfer; NAK_BYTE, default 8'h15, is returned when pslverr=1.
REQ-003 clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 rx_data_i  in  8  byte from the UART receiver.
REQ-006 rx_valid_i  in  1  rx_data_i is valid.
REQ-007 rx_ready_o  out  1  loader accepts a byte this cycle.
REQ-008 tx_data_o  out  8  response byte to the UART transmitter.
REQ-009 tx_valid_o  out  1  tx_data_o is valid.
REQ-010 tx_ready_i  in  1  transmitter accepts tx_data_o.
REQ-011 apb_req_o  out  dhs_apb_req_t  APB master request to the SoC apb_slv port.
REQ-012 apb_resp_i  in  dhs_apb_resp_t  APB response (pready, prdata, pslverr).
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 frame_err_o  out  1  one-cycle pulse on unknown command or byte timeout.

Function
REQ-015 A byte transfers on a rising edge with rx_valid_i=1 and rx_ready_o=1; a tx byte transfers with tx_valid_o=1 and tx_ready_i=1.
REQ-016 rx_ready_o is 1 only in states IDLE, ADDR and DATA; tx_valid_o is 1 only in RESP.
REQ-017 Frames: write = 8'hA5, addr[4 bytes LE], data[4 bytes LE]; read = 8'h5A, addr[4 bytes LE].
REQ-018 States: IDLE, ADDR, DATA, SETUP, ACCESS, RESP.
REQ-019 In IDLE, 8'hA5 or 8'h5A latches the command and moves to ADDR; any other byte is dropped, pulses frame_err_o, and the FSM stays in IDLE.
REQ-020 In ADDR, a 2-bit byte counter shifts each byte into addr[8*cnt +: 8]; after the 4th byte, write goes to DATA and read goes to SETUP.
REQ-021 DATA assembles wdata the same way; after the 4th byte it goes to SETUP.
REQ-022 In SETUP, the block drives psel=1, penable=0, paddr=addr, pwrite=cmd_is_write, pwdata=wdata, pstrb=4'hF for write and 4'h0 for read, then moves to ACCESS on the next edge.
REQ-023 In ACCESS, psel=1 and penable=1 with all other fields held; the FSM waits with no timeout until pready=1, then latches prdata and pslverr and moves to RESP.
REQ-024 Latency: last frame byte accepted at edge N -> SETUP in cycle N+1, ACCESS in cycle N+2, earliest first tx_valid_o in cycle N+3.
REQ-025 In RESP, a read emits prdata bytes 0..3 (LE) and then a status byte; a write emits only the status byte. Status is NAK_BYTE if pslverr=1, else ACK_BYTE.
REQ-026 Each RESP byte is held stable until it is accepted; after the status byte is accepted the FSM returns to IDLE.
REQ-027 In ADDR/DATA, an idle counter clears on every accepted byte and increments otherwise. When it reaches BYTE_TIMEOUT-1 with no byte, the FSM goes to IDLE and frame_err_o pulses; if a byte arrives in that same cycle, the byte wins and the counter clears.
REQ-028 apb_req_o is all-zero outside SETUP/ACCESS; psel never drops mid-transfer except on reset.

Reset
REQ-029 While rst_i=1 at an edge, the FSM goes to IDLE and the counters, addr, wdata and rdata clear.
REQ-030 After that edge, apb_req_o='0, tx_valid_o=0, rx_ready_o=1, busy_o=0 and frame_err_o=0.
REQ-031 Reset during ACCESS abandons the APB transfer; no response byte is sent.

Structure
REQ-032 dual_helix_pkg holds LDR_CMD_WRITE (8'hA5), LDR_CMD_READ (8'h5A) and the ldr_state_e enum.
REQ-033 The block uses the existing dhs_apb_req_t/dhs_apb_resp_t types.
REQ-034 The design is a single flat module; no sub-module is required.

Verification
REQ-035 Scenario: write frame A5 00 00 00 10 EF BE AD DE, pready=1 at first ACCESS -> one APB write with paddr=32'h1000_0000, pwdata=32'hDEAD_BEEF, pstrb=4'hF; tx emits 06.
REQ-036 Scenario: read frame 5A 04 00 00 10, prdata=32'h1234_5678 -> paddr=32'h1000_0004, pwrite=0; tx emits 78 56 34 12 06.
REQ-037 Scenario: write with pready delayed 5 cycles and pslverr=1 -> ACCESS held for 6 cycles, all fields stable; tx emits 15.
REQ-038 Scenario: byte 3C in IDLE -> frame_err_o pulses 1 cycle, no APB activity; a following valid frame completes normally.
REQ-039 Scenario: BYTE_TIMEOUT=16, send A5 00 then stall 16 cycles -> frame_err_o pulses and the FSM is in IDLE; a byte arriving on cycle 15 instead is accepted.
REQ-040 Scenario: tx_ready_i=0 for 10 cycles during a read response; also rst_i asserted mid-ACCESS -> tx bytes held unchanged while stalled; after the reset edge psel=0, no tx output, idle outputs as in REQ-030.
